bsm_pixel_serializer: RTL and testbench

Background pixel output stage that sits directly downstream of the GPU's background scanline memory (BSM). BSM holds 32 entries of 19 bits: [18:16] = colour, [15:0] = 8 pixels × 2 bits.
- Reads one BSM entry per tile over a synchronous-read port.
- Double-buffers each entry and shifts out one pixel per clk while the line is visible.
- Drives registered 2-bit r/g/b, with hsync/vsync delayed to stay aligned.

---
 rtl/bsm_pixel_serializer_pkg.sv | 31 +++
 rtl/bsm_pixel_serializer_pixel_colour_map.sv | 21 ++
 rtl/bsm_pixel_serializer.sv | 144 ++++++++++++++
 tb/tb_bsm_pixel_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bsm_pixel_serializer_pkg.sv
// Shared definitions for the background scanline pixel serializer:
// BSM entry layout, tile geometry and FSM state encoding.
package bsm_pixel_serializer_pkg;

    localparam int NUM_TILES  = 32;
    localparam int TILE_W     = 8;
    localparam int BSM_W      = 19;
    localparam int LINE_W     = 2 * TILE_W;
    localparam int COLOUR_MSB = 18;
    localparam int COLOUR_LSB = 16;
    localparam int LINE_MSB   = 15;
    localparam int LINE_LSB   = 0;

    localparam logic [4:0] LAST_TILE = 5'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_WAIT0    = 2'd2,
        ST_ACTIVE   = 2'd3
    } bsm_state_e;

    function automatic logic [2:0] bsm_colour(input logic [BSM_W-1:0] w);
        return w[COLOUR_MSB:COLOUR_LSB];
    endfunction

    function automatic logic [LINE_W-1:0] bsm_line(input logic [BSM_W-1:0] w);
        return w[LINE_MSB:LINE_LSB];
    endfunction

endpackage

// File: rtl/bsm_pixel_serializer_pixel_colour_map.sv
// Maps a 2-bit pixel and a 3-bit tile colour to 2-bit r/g/b channels;
// pixel value 00 is black regardless of colour.
module pixel_colour_map_m (
    input  logic [1:0] pix_i,
    input  logic [2:0] colour_i,
    output logic [1:0] r_o,
    output logic [1:0] g_o,
    output logic [1:0] b_o
);

    // Each colour bit gates the pixel intensity onto its channel.
    always_comb begin
        r_o = 2'b00;
        g_o = 2'b00;
        b_o = 2'b00;
        if (colour_i[2]) r_o = pix_i; else r_o = 2'b00;
        if (colour_i[1]) g_o = pix_i; else g_o = 2'b00;
        if (colour_i[0]) b_o = pix_i; else b_o = 2'b00;
    end

endmodule

// File: rtl/bsm_pixel_serializer.sv
// Background pixel serializer: prefetches one BSM entry per tile, shifts out
// one 2-bit pixel per clock and drives registered r/g/b plus delayed syncs.
module bsm_pixel_serializer
    import bsm_pixel_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        xp,
    input  logic              hvisible,
    input  logic              vvisible,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              bsm_rd_en,
    output logic [4:0]        bsm_rd_idx,
    input  logic [BSM_W-1:0]  bsm_rd_data,
    output logic [1:0]        r,
    output logic [1:0]        g,
    output logic [1:0]        b,
    output logic              hsync,
    output logic              vsync
);

    bsm_state_e        state_q;
    logic [LINE_W-1:0] shift_word_q;
    logic [2:0]        colour_q;
    logic [BSM_W-1:0]  next_word_q;
    logic              rd_pend_q;
    logic              bsm_rd_en_q;
    logic [4:0]        bsm_rd_idx_q;
    logic [1:0]        r_q, g_q, b_q;
    logic              hsync_q, vsync_q;

    logic              vis_s;
    logic              load_first_s;
    logic [BSM_W-1:0]  first_word_s;
    logic [LINE_W-1:0] cur_line_s;
    logic [2:0]        cur_colour_s;
    logic [1:0]        pix_s;
    logic [1:0]        r_d, g_d, b_d;

    // Select the word feeding the current pixel; the first visible pixel
    // bypasses shift_word so it leaves on the same edge that loads it.
    always_comb begin
        vis_s        = hvisible && vvisible;
        load_first_s = (state_q == ST_WAIT0) && vis_s;
        if (rd_pend_q) first_word_s = bsm_rd_data;
        else           first_word_s = next_word_q;
        cur_line_s   = shift_word_q;
        cur_colour_s = colour_q;
        if (load_first_s) begin
            cur_line_s   = bsm_line(first_word_s);
            cur_colour_s = bsm_colour(first_word_s);
        end else begin
            cur_line_s   = shift_word_q;
            cur_colour_s = colour_q;
        end
        if (vis_s && (state_q == ST_ACTIVE || load_first_s)) pix_s = cur_line_s[LINE_W-1 -: 2];
        else                                                  pix_s = 2'b00;
    end

    pixel_colour_map_m u_colour_map (
        .pix_i    (pix_s),
        .colour_i (cur_colour_s),
        .r_o      (r_d),
        .g_o      (g_d),
        .b_o      (b_d)
    );

    // Line FSM, BSM read sequencing, shifter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_word_q <= '0;
            colour_q     <= 3'd0;
            next_word_q  <= '0;
            rd_pend_q    <= 1'b0;
            bsm_rd_en_q  <= 1'b0;
            bsm_rd_idx_q <= 5'd0;
            r_q          <= 2'b00;
            g_q          <= 2'b00;
            b_q          <= 2'b00;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
            rd_pend_q   <= bsm_rd_en_q;
            bsm_rd_en_q <= 1'b0;
            if (rd_pend_q) next_word_q <= bsm_rd_data;
            case (state_q)
                ST_IDLE: begin
                    if (vvisible && !hvisible) begin
                        state_q      <= ST_PREFETCH;
                        bsm_rd_en_q  <= 1'b1;
                        bsm_rd_idx_q <= 5'd0;
                    end
                end
                ST_PREFETCH: begin
                    if (vvisible && !hvisible) state_q <= ST_WAIT0;
                    else                       state_q <= ST_IDLE;
                end
                ST_WAIT0: begin
                    if (!vvisible) begin
                        state_q <= ST_IDLE;
                    end else if (hvisible) begin
                        state_q      <= ST_ACTIVE;
                        shift_word_q <= {cur_line_s[LINE_W-3:0], 2'b00};
                        colour_q     <= cur_colour_s;
                    end
                end
                ST_ACTIVE: begin
                    if (!vis_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (xp[2:0] == 3'd7) begin
                            shift_word_q <= bsm_line(next_word_q);
                            colour_q     <= bsm_colour(next_word_q);
                        end else begin
                            shift_word_q <= {shift_word_q[LINE_W-3:0], 2'b00};
                        end
                        // Registered strobe: decided at pixel 4 so it is high during pixel 5.
                        if (xp[2:0] == 3'd4 && xp[7:3] != LAST_TILE) begin
                            bsm_rd_en_q  <= 1'b1;
                            bsm_rd_idx_q <= xp[7:3] + 5'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bsm_rd_en  = bsm_rd_en_q;
    assign bsm_rd_idx = bsm_rd_idx_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;

endmodule

// File: tb/tb_bsm_pixel_serializer.sv
// Directed scoreboard bench for bsm_pixel_serializer with a synchronous-read
// BSM model; expected pixels are derived from the bench's own memory image.
module tb_bsm_pixel_serializer;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       rd_chk;
        logic       rd;
        logic [4:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  xp;
    logic        hvisible, vvisible, hsync_in, vsync_in;
    logic        bsm_rd_en;
    logic [4:0]  bsm_rd_idx;
    logic [18:0] bsm_rd_data;
    logic [1:0]  r, g, b;
    logic        hsync, vsync;

    logic [18:0] mem [32];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          line_rd_cnt;
    int          first_rd_idx;
    logic        prev_rd = 1'b0;

    bsm_pixel_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .xp          (xp),
        .hvisible    (hvisible),
        .vvisible    (vvisible),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .bsm_rd_en   (bsm_rd_en),
        .bsm_rd_idx  (bsm_rd_idx),
        .bsm_rd_data (bsm_rd_data),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    always #40 clk = ~clk;

    always @(posedge clk) begin
        if (bsm_rd_en) bsm_rd_data <= mem[bsm_rd_idx];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [7:0] x, input logic hv, input logic vv, input logic hs,
                         input logic vs, input logic in_rst, input logic pix_on, input logic rd_chk);
        exp_t        e;
        exp_t        got;
        logic [18:0] w;
        logic [1:0]  p;
        int          t;
        int          k;
        @(negedge clk);
        xp = x; hvisible = hv; vvisible = vv; hsync_in = hs; vsync_in = vs;
        t = int'(x) / 8;
        k = int'(x) % 8;
        w = mem[t];
        p = w[15 - 2 * k -: 2];
        e = '0;
        e.rd_chk = rd_chk;
        if (!in_rst) begin
            e.hs = hs;
            e.vs = vs;
            if (pix_on) begin
                e.r = w[18] ? p : 2'b00;
                e.g = w[17] ? p : 2'b00;
                e.b = w[16] ? p : 2'b00;
                e.rd  = (k == 4) && (t != 31);
                e.idx = 5'(t + 1);
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("r", 32'(r), 32'(got.r));
        chk("g", 32'(g), 32'(got.g));
        chk("b", 32'(b), 32'(got.b));
        chk("hsync", 32'(hsync), 32'(got.hs));
        chk("vsync", 32'(vsync), 32'(got.vs));
        if (got.rd_chk) begin
            chk("rd_en", 32'(bsm_rd_en), 32'(got.rd));
            if (got.rd) chk("rd_idx", 32'(bsm_rd_idx), 32'(got.idx));
        end
        if (bsm_rd_en) begin
            chk("rd_en_back_to_back", 32'(prev_rd), 32'd0);
            if (line_rd_cnt == 0) first_rd_idx = int'(bsm_rd_idx);
            line_rd_cnt++;
        end
        prev_rd = bsm_rd_en;
    endtask

    task automatic run_line(input logic vv, input int blank_len, input logic good, input int cut_x,
                            input int rst_x, input int exp_cnt, input logic vs_lvl);
        logic in_rst = 1'b0;
        logic pf_seen = 1'b0;
        logic hv;
        line_rd_cnt  = 0;
        first_rd_idx = -1;
        for (int i = 0; i < blank_len; i++)
            cycle(8'd0, 1'b0, vv, (i >= 2 && i < 5), vs_lvl, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 256; x++) begin
            if (x == rst_x) begin
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_r", 32'(r), 32'd0);
                chk("rst_g", 32'(g), 32'd0);
                chk("rst_b", 32'(b), 32'd0);
                chk("rst_rd_en", 32'(bsm_rd_en), 32'd0);
                chk("rst_hsync", 32'(hsync), 32'd0);
                in_rst = 1'b1;
            end
            hv = (x < cut_x);
            cycle(8'(x), hv, vv, 1'b0, vs_lvl, in_rst, good && hv && vv && !in_rst, hv || in_rst);
            if (x >= cut_x && bsm_rd_en && bsm_rd_idx == 5'd0) pf_seen = 1'b1;
        end
        if (exp_cnt >= 0) chk("line_rd_count", 32'(line_rd_cnt), 32'(exp_cnt));
        if (exp_cnt == 32) chk("prefetch_idx", 32'(first_rd_idx), 32'd0);
        if (cut_x < 256) chk("prefetch_after_cut", 32'(pf_seen), 32'd1);
        if (in_rst) begin
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0; xp = 8'd0; hvisible = 1'b0; vvisible = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; bsm_rd_data = 19'd0;
        for (int i = 0; i < 32; i++) mem[i] = 19'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_r", 32'(r), 32'd0);
        chk("reset_g", 32'(g), 32'd0);
        chk("reset_b", 32'(b), 32'd0);
        chk("reset_hsync", 32'(hsync), 32'd0);
        chk("reset_vsync", 32'(vsync), 32'd0);
        chk("reset_rd_en", 32'(bsm_rd_en), 32'd0);
        chk("reset_rd_idx", 32'(bsm_rd_idx), 32'd0);
        rst = 1'b1;

        // Grey ramp in tile 0 only.
        mem[0] = 19'b111_00_01_10_11_00_01_10_11;
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        // Solid red, full intensity.
        for (int i = 0; i < 32; i++) mem[i] = {3'b100, 16'hFFFF};
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        // Alternating green/blue tiles.
        for (int i = 0; i < 32; i++) mem[i] = {((i % 2) == 1) ? 3'b010 : 3'b001, 16'hFFFF};
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        // Vertically blanked line with vsync active.
        run_line(1'b0, 8, 1'b0, 256, 256, 0, 1'b1);
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        // hvisible cut at x=100; prefetch already done for the next line.
        for (int i = 0; i < 32; i++) mem[i] = 19'($urandom);
        run_line(1'b1, 8, 1'b1, 100, 256, -1, 1'b0);
        run_line(1'b1, 8, 1'b1, 256, 256, 31, 1'b0);

        // Reset asserted mid-line, then a full line.
        for (int i = 0; i < 32; i++) mem[i] = {3'b111, 16'hFFFF};
        run_line(1'b1, 8, 1'b1, 256, 50, -1, 1'b0);
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        // One-clock blank misses the prefetch: black line, no reads.
        run_line(1'b1, 1, 1'b0, 256, 256, 0, 1'b0);
        for (int i = 0; i < 32; i++) mem[i] = 19'($urandom);
        run_line(1'b1, 8, 1'b1, 256, 256, 32, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
